// File: rtl/dedup_pairs.sv
// Decodes a pair-duplicated stream: each upstream pair (A,B) yields one output A.
// Mismatched pairs and odd element counts raise a sticky error flag when CHECK is set.
module dedup_pairs #(
  parameter int unsigned WIDTH = 32,
  parameter bit          CHECK = 1'b1
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] _in_0,
  input  logic                    _in_valid,
  input  logic                    _in_done,
  output logic                    _in_ready,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0,
  output logic                    _error,
  output logic [31:0]             _count
);

  typedef enum logic [1:0] {StDone, StFirst, StSecond, StEmit} state_e;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] a_q, a_d;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    in_ready_q, in_ready_d;
  logic                    error_q, error_d;
  logic                    last_q, last_d;
  logic [31:0]             count_q, count_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = _in_valid && in_ready_q;
  assign out_xfer = valid_q && _ready;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    out_d      = out_q;
    valid_d    = valid_q;
    done_d     = done_q;
    in_ready_d = in_ready_q;
    error_d    = error_q;
    last_d     = last_q;
    count_d    = count_q;

    if (_start) begin
      state_d    = StFirst;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      in_ready_d = 1'b1;
      error_d    = 1'b0;
      last_d     = 1'b0;
      count_d    = '0;
    end else begin
      unique case (state_q)
        StFirst: begin
          if (in_xfer) begin
            a_d        = _in_0;
            in_ready_d = 1'b1;
            state_d    = StSecond;
          end else if (_in_done) begin
            done_d     = 1'b1;
            in_ready_d = 1'b0;
            state_d    = StDone;
          end
        end
        StSecond: begin
          if (in_xfer) begin
            out_d      = a_q;
            valid_d    = 1'b1;
            in_ready_d = 1'b0;
            last_d     = 1'b0;
            if (CHECK && (_in_0 != a_q)) error_d = 1'b1;
            state_d    = StEmit;
          end else if (_in_done) begin
            // Odd element count: flush the unpaired A as the final output.
            out_d      = a_q;
            valid_d    = 1'b1;
            in_ready_d = 1'b0;
            last_d     = 1'b1;
            if (CHECK) error_d = 1'b1;
            state_d    = StEmit;
          end
        end
        StEmit: begin
          if (out_xfer) begin
            valid_d = 1'b0;
            count_d = count_q + 32'd1;
            if (last_q) begin
              done_d     = 1'b1;
              in_ready_d = 1'b0;
              state_d    = StDone;
            end else begin
              in_ready_d = 1'b1;
              state_d    = StFirst;
            end
          end
        end
        StDone: begin
          done_d     = 1'b1;
          valid_d    = 1'b0;
          in_ready_d = 1'b0;
        end
        default: state_d = StDone;
      endcase
    end
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q    <= StDone;
      a_q        <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b1;
      in_ready_q <= 1'b0;
      error_q    <= 1'b0;
      last_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
      error_q    <= error_d;
      last_q     <= last_d;
      count_q    <= count_d;
    end
  end

  assign _in_ready = in_ready_q;
  assign _valid    = valid_q;
  assign _done     = done_q;
  assign _0        = out_q;
  assign _error    = error_q;
  assign _count    = count_q;

endmodule
